// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: in-order pipeline writeback, long-latency result
// handshake and the registered register-file write port.
interface wb_arbiter_if #(
   parameter int unsigned XLEN = 32
);
   logic [4:0]      pipe_rd_addr_i;
   logic [XLEN-1:0] pipe_rd_data_i;
   logic            pipe_rd_we_i;
   logic            lu_valid_i;
   logic [4:0]      lu_rd_addr_i;
   logic [XLEN-1:0] lu_rd_data_i;
   logic            lu_ready_o;
   logic            stall_o;
   logic [4:0]      rd_addr_o;
   logic [XLEN-1:0] rd_data_o;
   logic            rd_we_o;

   modport master (
      output pipe_rd_addr_i, pipe_rd_data_i, pipe_rd_we_i,
      output lu_valid_i, lu_rd_addr_i, lu_rd_data_i,
      input  lu_ready_o, stall_o, rd_addr_o, rd_data_o, rd_we_o
   );

   modport slave (
      input  pipe_rd_addr_i, pipe_rd_data_i, pipe_rd_we_i,
      input  lu_valid_i, lu_rd_addr_i, lu_rd_data_i,
      output lu_ready_o, stall_o, rd_addr_o, rd_data_o, rd_we_o
   );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: in-order pipeline writeback versus a 2-entry
// FIFO of long-latency results, with a starvation limit that forces a pipe stall.
module wb_arbiter #(
   parameter int unsigned STARVE_MAX = 3,
   parameter int unsigned XLEN       = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   wb_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      GNT_IDLE,
      GNT_PIPE,
      GNT_LU
   } grant_e;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [4:0]      fifo_addr [2];
   logic [XLEN-1:0] fifo_data [2];
   logic            wr_ptr;
   logic            rd_ptr;
   logic [1:0]      count;
   logic [3:0]      starve_cnt;

   grant_e          grant;
   logic            pipe_eff;
   logic            fifo_empty;
   logic            lu_ready;
   logic            push;
   logic            pop;

   always_comb begin
      pipe_eff   = bus.pipe_rd_we_i && (bus.pipe_rd_addr_i != '0);
      fifo_empty = (count == 2'd0);
      lu_ready   = (count < 2'd2);
      push       = bus.lu_valid_i && lu_ready;

      grant = GNT_IDLE;
      if (!fifo_empty && (!pipe_eff || (starve_cnt == STARVE_LIM))) begin
         grant = GNT_LU;
      end else if (pipe_eff) begin
         grant = GNT_PIPE;
      end

      pop            = (grant == GNT_LU);
      bus.lu_ready_o = lu_ready;
      bus.stall_o    = pipe_eff && pop;
   end

   // Payload storage needs no reset; count and pointers alone define validity.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_addr[wr_ptr] <= bus.lu_rd_addr_i;
         fifo_data[wr_ptr] <= bus.lu_rd_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_cnt <= '0;
      end else if (pop || fifo_empty) begin
         starve_cnt <= '0;
      end else if ((grant == GNT_PIPE) && (starve_cnt != STARVE_LIM)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bus.rd_addr_o <= '0;
         bus.rd_data_o <= '0;
         bus.rd_we_o   <= 1'b0;
      end else begin
         case (grant)
            GNT_PIPE: begin
               bus.rd_addr_o <= bus.pipe_rd_addr_i;
               bus.rd_data_o <= bus.pipe_rd_data_i;
               bus.rd_we_o   <= 1'b1;
            end
            GNT_LU: begin
               bus.rd_addr_o <= fifo_addr[rd_ptr];
               bus.rd_data_o <= fifo_data[rd_ptr];
               bus.rd_we_o   <= 1'b1;
            end
            default: begin
               bus.rd_we_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3, is the number of consecutive pipeline-granted cycles a waiting long-latency result tolerates before it forces a stall (legal range 1..15).
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 pipe_rd_addr_i  input  5  destination register of the in-order pipeline writeback.
REQ-005 pipe_rd_data_i  input  `XLEN  pipeline writeback data.
REQ-006 pipe_rd_we_i  input  1  pipeline write request.
REQ-007 lu_valid_i  input  1  long-latency unit (mul/div) result valid.
REQ-008 lu_rd_addr_i  input  5  long-latency result destination register.
REQ-009 lu_rd_data_i  input  `XLEN  long-latency result data.
REQ-010 lu_ready_o  output  1  arbiter can accept a long-latency result this cycle.
REQ-011 stall_o  output  1  pipeline must hold its current writeback this cycle; it is not consumed.
REQ-012 rd_addr_o  output  5  register-file write address, registered.
REQ-013 rd_data_o  output  `XLEN  register-file write data, registered.
REQ-014 rd_we_o  output  1  register-file write enable, registered.

Function
REQ-015 Long-latency results SHALL be buffered in a 2-entry FIFO (addr+data), in acceptance order.
REQ-016 lu_ready_o SHALL be 1 iff FIFO count < 2; a push SHALL occur iff lu_valid_i && lu_ready_o.
REQ-017 Pipe request is effective iff pipe_rd_we_i=1 and pipe_rd_addr_i!=0; requests to x0 SHALL be dropped with no write and no grant.
REQ-018 Each cycle exactly one of: grant PIPE, grant LU, or idle.
REQ-019 Grant LU iff FIFO non-empty and (no effective pipe request or starve_cnt==STARVE_MAX); grant LU pops the FIFO head.
REQ-020 Otherwise grant PIPE iff effective pipe request; otherwise idle.
REQ-021 stall_o SHALL be combinational: 1 iff effective pipe request and LU granted in the same cycle.
REQ-022 starve_cnt (4 bits): on grant PIPE with FIFO non-empty, increment, saturating at STARVE_MAX; on grant LU or FIFO empty, clear to 0.
REQ-023 Granted entry SHALL appear on rd_addr_o/rd_data_o with rd_we_o=1 on the next rising edge; on idle, rd_we_o=0 and rd_addr_o/rd_data_o hold their prior values.
REQ-024 Latency: pipe request at cycle N -> rd_we_o at N+1 when granted; LU push at cycle N -> earliest rd_we_o at N+2 (no bypass around the FIFO).
REQ-025 Simultaneous push and pop with count=1 SHALL leave count=1 with order preserved; with count=2 no push occurs, the pop frees a slot visible as lu_ready_o=1 next cycle.
REQ-026 The arbiter SHALL NOT compare addresses between pipe and LU entries; RAW/WAW ordering is the hazard unit's responsibility.
REQ-027 FIFO read/write pointers SHALL wrap modulo 2; count SHALL never exceed 2 or underflow.

Reset
REQ-028 While rst_i=1: FIFO empty, pointers 0, starve_cnt=0, rd_addr_o=0, rd_data_o=0, rd_we_o=0, lu_ready_o=1, stall_o=0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered results immediately, without waiting for a clock edge.
REQ-030 First grant after reset release SHALL occur no earlier than the first rising edge with rst_i=0.

Verification
REQ-031 Pipe only: pipe (rd=5, data=0x1234, we=1) at N -> rd_we_o=1, rd_addr_o=5, rd_data_o=0x1234 at N+1; stall_o stays 0.
REQ-032 x0 drop: pipe (rd=0, data=0xFFFF, we=1) -> rd_we_o=0 next cycle, outputs unchanged, a pending LU entry is granted instead.
REQ-033 Starvation: push LU (rd=7, 0xAA) then pipe requests every cycle with STARVE_MAX=3 -> three PIPE grants, then stall_o=1 for one cycle, rd_addr_o=7/0xAA written, starve_cnt=0.
REQ-034 FIFO full: push LU rd=1 and rd=2 while pipe busy -> lu_ready_o=0; third lu_valid_i ignored; drain order rd=1 then rd=2.
REQ-035 Idle LU: push LU (rd=9, 0x55) at N with no pipe requests -> rd_we_o=1, rd_addr_o=9 at N+2; lu_ready_o stays 1.
REQ-036 Async reset: FIFO holding 2 entries, rst_i pulsed between edges -> rd_we_o=0, lu_ready_o=1 immediately; no stale entry written after release.
